// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780 write sequencer behind the LSU LCD register.
// Captures byte writes and drives setup/EN/hold/exec timing on the pins.
module lcd_ctrl #(
  parameter int unsigned T_POWERUP   = 750000,
  parameter int unsigned T_SETUP     = 2,
  parameter int unsigned T_PULSE     = 12,
  parameter int unsigned T_HOLD      = 2,
  parameter int unsigned T_EXEC      = 2000,
  parameter int unsigned T_EXEC_LONG = 82000,
  parameter int unsigned CNT_W       = 20
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] lcd_reg_i,
  output logic [7:0]  lcd_data_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic        lcd_en_o,
  output logic        lcd_on_o,
  output logic [31:0] status_o
);

  typedef enum logic [2:0] {
    POWERUP,
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    EXEC
  } state_t;

  localparam logic [CNT_W-1:0] PU_END  = CNT_W'(T_POWERUP);
  localparam logic [CNT_W-1:0] LD_SET  = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_PUL  = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] LD_HLD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_EXE  = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] LD_LONG = CNT_W'(T_EXEC_LONG - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             req_q, clr_q;
  logic             req_edge, clr_edge;
  logic             tmr_zero, long_cmd;
  logic             pend_v_q, pend_v_d;
  logic [8:0]       pend_q, pend_d;
  logic [8:0]       req_val, go_val, cur_d;
  logic             go;
  logic             ovf_q, ovf_d;
  logic             init_q, init_d;
  logic             busy_d;
  logic [3:0]       status_q;
  logic             unused_bits;

  assign unused_bits = ^{lcd_reg_i[30:12], lcd_reg_i[8]};
  assign req_edge = lcd_reg_i[10] & ~req_q;
  assign clr_edge = lcd_reg_i[11] & ~clr_q;
  assign req_val  = {lcd_reg_i[9], lcd_reg_i[7:0]};
  assign tmr_zero = (timer_q == '0);
  // clear (0x01) and return-home (0x02/0x03) need the long wait
  assign long_cmd = ~lcd_rs_o
                  & (lcd_data_o[7:2] == 6'd0)
                  & (lcd_data_o[1:0] != 2'd0);
  assign lcd_rw_o = 1'b0;
  assign status_o = {28'd0, status_q};
  assign busy_d   = (state_d != IDLE) | pend_v_d;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    pend_v_d = pend_v_q;
    pend_d   = pend_q;
    cur_d    = {lcd_rs_o, lcd_data_o};
    ovf_d    = ovf_q;
    init_d   = init_q;
    go       = 1'b0;
    go_val   = req_val;
    unique case (state_q)
      POWERUP: begin
        if (timer_q == PU_END) begin
          init_d = 1'b1;
          if (pend_v_q) begin
            go       = 1'b1;
            go_val   = pend_q;
            pend_v_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q + ONE;
        end
      end
      IDLE: ;
      SETUP: begin
        if (tmr_zero) begin
          state_d = PULSE;
          timer_d = LD_PUL;
        end else begin
          timer_d = timer_q - ONE;
        end
      end
      PULSE: begin
        if (tmr_zero) begin
          state_d = HOLD;
          timer_d = LD_HLD;
        end else begin
          timer_d = timer_q - ONE;
        end
      end
      HOLD: begin
        if (tmr_zero) begin
          state_d = EXEC;
          timer_d = long_cmd ? LD_LONG : LD_EXE;
        end else begin
          timer_d = timer_q - ONE;
        end
      end
      EXEC: begin
        if (tmr_zero) begin
          if (pend_v_q) begin
            go       = 1'b1;
            go_val   = pend_q;
            pend_v_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - ONE;
        end
      end
      default: state_d = POWERUP;
    endcase

    // set wins over clear when both land together
    if (clr_edge) ovf_d = 1'b0;
    if (req_edge) begin
      if (state_d == IDLE && !go) begin
        go     = 1'b1;
        go_val = req_val;
      end else if (!pend_v_q) begin
        pend_v_d = 1'b1;
        pend_d   = req_val;
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (go) begin
      state_d = SETUP;
      timer_d = LD_SET;
      cur_d   = go_val;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      state_q    <= POWERUP;
      timer_q    <= '0;
      req_q      <= 1'b0;
      clr_q      <= 1'b0;
      pend_v_q   <= 1'b0;
      pend_q     <= '0;
      ovf_q      <= 1'b0;
      init_q     <= 1'b0;
      lcd_data_o <= '0;
      lcd_rs_o   <= 1'b0;
      lcd_en_o   <= 1'b0;
      lcd_on_o   <= 1'b0;
      status_q   <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      req_q      <= lcd_reg_i[10];
      clr_q      <= lcd_reg_i[11];
      pend_v_q   <= pend_v_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
      init_q     <= init_d;
      lcd_rs_o   <= cur_d[8];
      lcd_data_o <= cur_d[7:0];
      lcd_en_o   <= (state_d == PULSE);
      lcd_on_o   <= lcd_reg_i[31];
      status_q   <= {init_d, ovf_d, pend_v_d, busy_d};
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: scoreboard bench for the LCD write sequencer.
// Accepted requests queue {rs,data}; each EN pulse pops and compares.
module tb_lcd_ctrl;

  localparam int TPU = 10;
  localparam int TS  = 1;
  localparam int TP  = 2;
  localparam int TH  = 1;
  localparam int TE  = 5;
  localparam int TEL = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        on_b = 1'b0;
  logic        clr_b = 1'b0;
  logic        req_b = 1'b0;
  logic        rs_b = 1'b0;
  logic [7:0]  data_b = 8'd0;
  logic [31:0] lcd_reg;
  logic [7:0]  lcd_data;
  logic        lcd_rs, lcd_rw, lcd_en, lcd_on;
  logic [31:0] status;

  int nchk = 0;
  int nerr = 0;
  int pulses = 0;
  int width = 0;
  bit cut = 1'b0;
  logic en_prev = 1'b0;
  logic [8:0] sb_q[$];
  logic [8:0] exp_v;

  assign lcd_reg = {on_b, 19'd0, clr_b, req_b, rs_b, 1'b0, data_b};

  lcd_ctrl #(
    .T_POWERUP  (TPU),
    .T_SETUP    (TS),
    .T_PULSE    (TP),
    .T_HOLD     (TH),
    .T_EXEC     (TE),
    .T_EXEC_LONG(TEL),
    .CNT_W      (20)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst),
    .lcd_reg_i (lcd_reg),
    .lcd_data_o(lcd_data),
    .lcd_rs_o  (lcd_rs),
    .lcd_rw_o  (lcd_rw),
    .lcd_en_o  (lcd_en),
    .lcd_on_o  (lcd_on),
    .status_o  (status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic rs, input logic [7:0] d, input bit push);
    rs_b   = rs;
    data_b = d;
    req_b  = 1'b1;
    if (push) sb_q.push_back({rs, d});
    tick();
    req_b = 1'b0;
  endtask

  task automatic wait_idle(input int start, output int n);
    n = start;
    while (status[0] && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic check_powerup();
    for (int i = 0; i < TPU; i++) begin
      tick();
      chk("pu_status", status, 32'h1);
      chk("pu_en", {31'd0, lcd_en}, 32'd0);
    end
    tick();
    chk("pu_done", status, 32'h8);
  endtask

  // EN pulse monitor: pops expected {rs,data} and checks pulse width
  always @(negedge clk) begin
    if (lcd_en && !en_prev) begin
      pulses++;
      width = 1;
      cut   = 1'b0;
      chk("sb_nonempty", {31'd0, sb_q.size() > 0}, 32'd1);
      if (sb_q.size() > 0) begin
        exp_v = sb_q.pop_front();
        chk("pulse_rs_data", {23'd0, lcd_rs, lcd_data}, {23'd0, exp_v});
      end
    end else if (lcd_en) begin
      width++;
    end else if (en_prev && !cut) begin
      chk("pulse_width", width, TP);
    end
    if (rst) cut = 1'b1;
    en_prev = lcd_en;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int p0;

    // reset state
    tick();
    tick();
    chk("rst_status", status, 32'd0);
    chk("rst_pins", {20'd0, lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on},
        32'd0);
    rst = 1'b0;
    check_powerup();

    // data write 'A'
    on_b = 1'b1;
    send(1'b1, 8'h41, 1'b1);
    chk("wr_on", {31'd0, lcd_on}, 32'd1);
    chk("wr_rsdata", {23'd0, lcd_rs, lcd_data}, 32'h141);
    chk("wr_setup_en", {31'd0, lcd_en}, 32'd0);
    chk("wr_busy", status, 32'h9);
    tick();
    chk("wr_en_k2", {31'd0, lcd_en}, 32'd1);
    tick();
    chk("wr_en_k3", {31'd0, lcd_en}, 32'd1);
    tick();
    chk("wr_en_k4", {31'd0, lcd_en}, 32'd0);
    chk("wr_hold", {23'd0, lcd_rs, lcd_data}, 32'h141);
    wait_idle(4, n);
    chk("wr_idle_at", n, TS + TP + TH + TE + 1);
    chk("wr_status", status, 32'h8);

    // clear display uses the long exec wait
    p0 = pulses;
    send(1'b0, 8'h01, 1'b1);
    wait_idle(1, n);
    chk("clr_idle_at", n, TS + TP + TH + TEL + 1);
    chk("clr_pulses", pulses - p0, 1);
    send(1'b0, 8'h38, 1'b1);
    wait_idle(1, n);
    chk("fnset_idle_at", n, TS + TP + TH + TE + 1);

    // overflow: pending serviced back-to-back, third edge dropped
    p0 = pulses;
    send(1'b1, 8'h42, 1'b1);
    tick();
    send(1'b1, 8'h43, 1'b1);
    chk("ovf_pending", status, 32'hB);
    tick();
    send(1'b0, 8'h55, 1'b0);
    chk("ovf_set", status, 32'hF);
    wait_idle(5, n);
    chk("ovf_idle_at", n, 2 * (TS + TP + TH + TE) + 1);
    chk("ovf_pulses", pulses - p0, 2);
    chk("ovf_sticky", status, 32'hC);
    clr_b = 1'b1;
    tick();
    clr_b = 1'b0;
    chk("ovf_clr", status, 32'h8);

    // reset in the middle of PULSE
    send(1'b1, 8'h77, 1'b1);
    tick();
    chk("mid_en", {31'd0, lcd_en}, 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_en", {31'd0, lcd_en}, 32'd0);
    chk("mid_rst_status", status, 32'd0);
    chk("mid_rst_pins", {22'd0, lcd_data, lcd_rs, lcd_on}, 32'd0);
    rst = 1'b0;
    p0 = pulses;
    check_powerup();
    chk("mid_no_pulse", pulses - p0, 0);

    // held REQ gives one transaction
    p0 = pulses;
    rs_b   = 1'b1;
    data_b = 8'h48;
    req_b  = 1'b1;
    sb_q.push_back({1'b1, 8'h48});
    for (int i = 0; i < 50; i++) tick();
    req_b = 1'b0;
    wait_idle(0, n);
    chk("held_pulses", pulses - p0, 1);
    chk("held_status", status, 32'h8);

    // request during POWERUP waits in pending
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    send(1'b1, 8'h45, 1'b1);
    chk("early_pend", status, 32'h3);
    n = 0;
    while (!status[3] && n < 30) begin
      tick();
      n++;
    end
    chk("early_init", status, 32'h9);
    chk("early_rsdata", {23'd0, lcd_rs, lcd_data}, 32'h145);
    chk("early_en0", {31'd0, lcd_en}, 32'd0);
    tick();
    chk("early_en1", {31'd0, lcd_en}, 32'd1);
    wait_idle(0, n);
    chk("early_done", status, 32'h8);

    tick();
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
